// File: rtl/sram_port_arbiter.sv
// Two-port round-robin front end for a single-port SRAM macro.
// After reset or a reinit request, every entry is cleared to zero, one
// entry per cycle. Two requesters then share the macro's single RW port.
// Reads return data one cycle after they are accepted.
module sram_port_arbiter #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 80,
   parameter int MASK_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic [MASK_W-1:0] req0_wmask,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic [MASK_W-1:0] req1_wmask,
   output logic              resp0_valid,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              init_done,
   input  logic              reinit,
   output logic              ram_en,
   output logic              ram_wmode,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [MASK_W-1:0] ram_wmask,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } arbState_e;

   localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

   arbState_e         state;
   arbState_e         nextState;
   logic [ADDR_W-1:0] clearCount;
   logic [ADDR_W-1:0] nextClearCount;
   logic              favourReq1;
   logic              nextFavourReq1;
   logic              grant0;
   logic              grant1;
   logic              resp0Reg;
   logic              resp1Reg;

   // Architectural state. The clear counter, the round-robin priority bit
   // and the pending-read flags all live here. A read accepted this cycle
   // raises its response flag for exactly the following cycle. Reset drops
   // any response that is still in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= INIT;
         clearCount <= '0;
         favourReq1 <= 1'b0;
         resp0Reg   <= 1'b0;
         resp1Reg   <= 1'b0;
      end else begin
         state      <= nextState;
         clearCount <= nextClearCount;
         favourReq1 <= nextFavourReq1;
         resp0Reg   <= grant0 & ~req0_write;
         resp1Reg   <= grant1 & ~req1_write;
      end
   end

   // Next-state logic and macro command mux.
   // INIT writes zeros to one entry per cycle and hands over to RUN after
   // the last entry. The INIT drive is gated by reset so that the macro
   // stays idle while reset is held.
   // In RUN, a lone requester always wins. When both requesters are valid,
   // the one not served most recently wins. The winner's fields go straight
   // to the macro in the same cycle. A reinit request blocks all grants and
   // restarts the clear sequence.
   always_comb begin
      nextState      = state;
      nextClearCount = clearCount;
      nextFavourReq1 = favourReq1;
      grant0         = 1'b0;
      grant1         = 1'b0;
      ram_en         = 1'b0;
      ram_wmode      = 1'b0;
      ram_addr       = '0;
      ram_wmask      = '0;
      ram_wdata      = '0;
      case (state)
         INIT: begin
            if (!reset) begin
               ram_en    = 1'b1;
               ram_wmode = 1'b1;
               ram_addr  = clearCount;
               ram_wmask = '1;
               ram_wdata = '0;
            end
            if (clearCount == LAST_ENTRY) begin
               nextState      = RUN;
               nextClearCount = '0;
            end else begin
               nextClearCount = clearCount + ADDR_W'(1);
            end
         end
         RUN: begin
            if (reinit) begin
               nextState      = INIT;
               nextClearCount = '0;
            end else begin
               if (req0_valid && (!req1_valid || !favourReq1)) begin
                  grant0 = 1'b1;
               end else if (req1_valid) begin
                  grant1 = 1'b1;
               end
               if (grant0) begin
                  ram_en         = 1'b1;
                  ram_wmode      = req0_write;
                  ram_addr       = req0_addr;
                  ram_wmask      = req0_wmask;
                  ram_wdata      = req0_wdata;
                  nextFavourReq1 = 1'b1;
               end else if (grant1) begin
                  ram_en         = 1'b1;
                  ram_wmode      = req1_write;
                  ram_addr       = req1_addr;
                  ram_wmask      = req1_wmask;
                  ram_wdata      = req1_wdata;
                  nextFavourReq1 = 1'b0;
               end
            end
         end
         default: begin
            nextState      = INIT;
            nextClearCount = '0;
         end
      endcase
   end

   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign resp0_valid = resp0Reg;
   assign resp1_valid = resp1Reg;
   assign resp_rdata  = ram_rdata;
   assign init_done   = (state == RUN);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter.
// The stimulus side drives randomized and directed traffic. It keeps a
// plain reference model of the arbiter: grant rule, clear timing and
// memory contents. It queues the responses it expects.
// A separate negedge monitor compares the DUT outputs against the model's
// expectations and pops the response queue.
// A second instance with DEPTH=24 checks the clear sequence when DEPTH is
// not a power of two.
module tb_sram_port_arbiter;

   localparam int DEPTH    = 64;
   localparam int ADDR_W   = 6;
   localparam int DATA_W   = 80;
   localparam int MASK_W   = 4;
   localparam int LANE_W   = DATA_W / MASK_W;
   localparam int DEPTH_S  = 24;
   localparam int ADDR_W_S = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              reinit;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic              req0_write, req1_write;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic [DATA_W-1:0] req0_wdata, req1_wdata;
   logic [MASK_W-1:0] req0_wmask, req1_wmask;
   logic              resp0_valid, resp1_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              init_done;
   logic              ram_en, ram_wmode;
   logic [ADDR_W-1:0] ram_addr;
   logic [MASK_W-1:0] ram_wmask;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic                smallReady0, smallReady1, smallResp0, smallResp1;
   logic [DATA_W-1:0]   smallRdata;
   logic                smallInitDone, smallRamEn, smallRamWmode;
   logic [ADDR_W_S-1:0] smallRamAddr;
   logic [MASK_W-1:0]   smallRamWmask;
   logic [DATA_W-1:0]   smallRamWdata;

   always #5 clock = ~clock;

   sram_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) uDut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_rdata(resp_rdata),
      .init_done(init_done), .reinit(reinit),
      .ram_en(ram_en), .ram_wmode(ram_wmode), .ram_addr(ram_addr),
      .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   sram_port_arbiter #(.DEPTH(DEPTH_S), .ADDR_W(ADDR_W_S), .DATA_W(DATA_W), .MASK_W(MASK_W)) uSmall (
      .clock(clock), .reset(reset),
      .req0_valid(1'b0), .req0_ready(smallReady0), .req0_write(1'b0),
      .req0_addr('0), .req0_wdata('0), .req0_wmask('0),
      .req1_valid(1'b0), .req1_ready(smallReady1), .req1_write(1'b0),
      .req1_addr('0), .req1_wdata('0), .req1_wmask('0),
      .resp0_valid(smallResp0), .resp1_valid(smallResp1), .resp_rdata(smallRdata),
      .init_done(smallInitDone), .reinit(1'b0),
      .ram_en(smallRamEn), .ram_wmode(smallRamWmode), .ram_addr(smallRamAddr),
      .ram_wmask(smallRamWmask), .ram_wdata(smallRamWdata), .ram_rdata('0)
   );

   // Behavioural SRAM macro: masked writes; reads return the addressed word
   // on the following cycle.
   logic [DATA_W-1:0] sramMem [DEPTH];
   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_wmode) begin
            for (int l = 0; l < MASK_W; l++)
               if (ram_wmask[l]) sramMem[ram_addr][l*LANE_W +: LANE_W] <= ram_wdata[l*LANE_W +: LANE_W];
         end else begin
            ram_rdata <= sramMem[ram_addr];
         end
      end
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int                due;
      int                who;
      logic [DATA_W-1:0] data;
   } respT;
   respT respQ[$];

   // Reference model state
   bit                mRun;
   int                mCnt;
   bit                mFavour1;
   logic [DATA_W-1:0] modelMem [DEPTH];
   int                smallCycle;

   // Requester state: a request is held until it is granted
   bit                pendValid [2];
   bit                pendWrite [2];
   logic [ADDR_W-1:0] pendAddr  [2];
   logic [DATA_W-1:0] pendData  [2];
   logic [MASK_W-1:0] pendMask  [2];
   bit                grantedLast [2];
   int                writePct = 40;

   // Expectations for the current cycle
   bit                  checking = 1'b0;
   bit                  expReady [2];
   bit                  expInitDone, expRamEn, expRamWmode;
   logic [ADDR_W-1:0]   expRamAddr;
   logic [MASK_W-1:0]   expRamWmask;
   logic [DATA_W-1:0]   expRamWdata;
   bit                  expSmallEn, expSmallDone;
   logic [ADDR_W_S-1:0] expSmallAddr;

   int cmpCount  = 0;
   int failCount = 0;

   // Record one comparison; report it if the actual value differs from the
   // expected value.
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      cmpCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] randData();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[DATA_W-1:0];
   endfunction

   task automatic clearModelMem();
      for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
   endtask

   task automatic setRequest(input int n, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
      pendValid[n] = 1'b1;
      pendWrite[n] = wr;
      pendAddr[n]  = a;
      pendData[n]  = d;
      pendMask[n]  = m;
   endtask

   // Advance one cycle. The task first drives new inputs just after the
   // clock edge, then computes what the DUT must show during this cycle.
   // For a new request, reqPct is the percent chance that an idle
   // requester raises one.
   task automatic applyStimulus(input bit rstVal, input bit reinitVal, input int reqPct);
      int winner;
      @(posedge clock);
      #1;
      for (int n = 0; n < 2; n++) begin
         if (grantedLast[n]) pendValid[n] = 1'b0;
         grantedLast[n] = 1'b0;
         if (!pendValid[n] && ($urandom_range(0, 99) < reqPct))
            setRequest(n, $urandom_range(0, 99) < writePct,
                       $urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, DEPTH - 1)),
                       randData(), MASK_W'($urandom));
      end
      reset      = rstVal;
      reinit     = reinitVal;
      req0_valid = pendValid[0]; req0_write = pendWrite[0]; req0_addr = pendAddr[0];
      req0_wdata = pendData[0];  req0_wmask = pendMask[0];
      req1_valid = pendValid[1]; req1_write = pendWrite[1]; req1_addr = pendAddr[1];
      req1_wdata = pendData[1];  req1_wmask = pendMask[1];

      expReady[0] = 1'b0; expReady[1] = 1'b0;
      expInitDone = 1'b0; expRamEn = 1'b0; expRamWmode = 1'b0;
      expRamAddr  = '0;   expRamWmask = '0; expRamWdata = '0;
      checking    = 1'b1;

      if (rstVal) begin
         mRun = 1'b0; mCnt = 0; mFavour1 = 1'b0; smallCycle = 0;
         expSmallEn = 1'b0; expSmallDone = 1'b0; expSmallAddr = '0;
         respQ.delete();
         clearModelMem();
         return;
      end

      expSmallEn   = (smallCycle < DEPTH_S);
      expSmallDone = (smallCycle >= DEPTH_S);
      expSmallAddr = ADDR_W_S'(smallCycle);
      if (smallCycle < 1000) smallCycle++;

      if (!mRun) begin
         expRamEn    = 1'b1;
         expRamWmode = 1'b1;
         expRamAddr  = ADDR_W'(mCnt);
         expRamWmask = '1;
         expRamWdata = '0;
         if (mCnt == DEPTH - 1) mRun = 1'b1;
         else mCnt++;
      end else begin
         expInitDone = 1'b1;
         if (reinitVal) begin
            mRun = 1'b0; mCnt = 0;
            clearModelMem();
         end else begin
            winner = -1;
            if (pendValid[0] && pendValid[1]) winner = mFavour1 ? 1 : 0;
            else if (pendValid[0]) winner = 0;
            else if (pendValid[1]) winner = 1;
            if (winner >= 0) begin
               expReady[winner]    = 1'b1;
               expRamEn            = 1'b1;
               expRamWmode         = pendWrite[winner];
               expRamAddr          = pendAddr[winner];
               expRamWmask         = pendMask[winner];
               expRamWdata         = pendData[winner];
               grantedLast[winner] = 1'b1;
               mFavour1            = (winner == 0);
               if (pendWrite[winner]) begin
                  for (int l = 0; l < MASK_W; l++)
                     if (pendMask[winner][l])
                        modelMem[pendAddr[winner]][l*LANE_W +: LANE_W] = pendData[winner][l*LANE_W +: LANE_W];
               end else begin
                  respQ.push_back('{due: cyc + 1, who: winner, data: modelMem[pendAddr[winner]]});
               end
            end
         end
      end
   endtask

   // Monitor comparison for one cycle. The task runs on the falling edge,
   // well away from the DUT's active clock edge.
   task automatic checkOutput();
      respT e;
      if (!checking) return;
      check("req0_ready", 128'(req0_ready), 128'(expReady[0]));
      check("req1_ready", 128'(req1_ready), 128'(expReady[1]));
      check("init_done", 128'(init_done), 128'(expInitDone));
      check("ram_en", 128'(ram_en), 128'(expRamEn));
      if (!reset) begin
         check("ram_wmode", 128'(ram_wmode), 128'(expRamWmode));
         check("ram_addr", 128'(ram_addr), 128'(expRamAddr));
         check("ram_wmask", 128'(ram_wmask), 128'(expRamWmask));
         check("ram_wdata", 128'(ram_wdata), 128'(expRamWdata));
      end
      if (respQ.size() > 0 && respQ[0].due == cyc) begin
         e = respQ.pop_front();
         check("resp0_valid", 128'(resp0_valid), 128'(e.who == 0));
         check("resp1_valid", 128'(resp1_valid), 128'(e.who == 1));
         check("resp_rdata", 128'(resp_rdata), 128'(e.data));
      end else begin
         check("resp0_valid idle", 128'(resp0_valid), 128'(0));
         check("resp1_valid idle", 128'(resp1_valid), 128'(0));
      end
      check("small_ram_en", 128'(smallRamEn), 128'(expSmallEn));
      check("small_init_done", 128'(smallInitDone), 128'(expSmallDone));
      check("small_ready", 128'({smallReady1, smallReady0}), 128'(0));
      check("small_addr_range", 128'(smallRamEn && (int'(smallRamAddr) >= DEPTH_S)), 128'(0));
      if (expSmallEn) begin
         check("small_ram_addr", 128'(smallRamAddr), 128'(expSmallAddr));
         check("small_ram_wmode", 128'(smallRamWmode), 128'(1));
      end
   endtask

   // Independent monitor process
   always @(negedge clock) checkOutput();

   // Directed and randomized sequences
   initial begin
      reset = 1'b1; reinit = 1'b0;
      req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
      req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
      for (int n = 0; n < 2; n++) begin
         pendValid[n] = 1'b0; grantedLast[n] = 1'b0;
      end
      clearModelMem();
      $display("[TB] reset and initial clear");
      repeat (3) applyStimulus(1'b1, 1'b0, 0);
      repeat (68) applyStimulus(1'b0, 1'b0, 0);

      $display("[TB] masked write then back-to-back read");
      setRequest(0, 1'b1, ADDR_W'(5), '1, 4'b0101);
      applyStimulus(1'b0, 1'b0, 0);
      setRequest(1, 1'b0, ADDR_W'(5), '0, '0);
      applyStimulus(1'b0, 1'b0, 0);
      repeat (3) applyStimulus(1'b0, 1'b0, 0);

      $display("[TB] continuous reads from both requesters");
      writePct = 0;
      repeat (16) applyStimulus(1'b0, 1'b0, 100);
      writePct = 40;
      repeat (4) applyStimulus(1'b0, 1'b0, 0);

      $display("[TB] random traffic");
      repeat (300) applyStimulus(1'b0, 1'b0, 70);
      repeat (6) applyStimulus(1'b0, 1'b0, 0);

      $display("[TB] reinit after a read");
      setRequest(1, 1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)), '0, '0);
      applyStimulus(1'b0, 1'b0, 0);
      setRequest(0, 1'b0, ADDR_W'(3), '0, '0);
      applyStimulus(1'b0, 1'b1, 0);
      repeat (10) applyStimulus(1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 0);
      repeat (60) applyStimulus(1'b0, 1'b0, 0);
      repeat (40) applyStimulus(1'b0, 1'b0, 60);
      repeat (6) applyStimulus(1'b0, 1'b0, 0);

      $display("[TB] reset mid-clear and on a read");
      for (int i = 0; i < 200 && !(!mRun && mCnt == 30); i++) applyStimulus(1'b0, 1'b1, 0);
      repeat (2) applyStimulus(1'b1, 1'b0, 0);
      for (int i = 0; i < 200 && !(!mRun && mCnt == 30); i++) applyStimulus(1'b0, 1'b0, 0);
      repeat (2) applyStimulus(1'b1, 1'b0, 0);
      for (int i = 0; i < 200 && !mRun; i++) applyStimulus(1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 0);
      setRequest(0, 1'b0, ADDR_W'(5), '0, '0);
      applyStimulus(1'b0, 1'b0, 0);
      repeat (2) applyStimulus(1'b1, 1'b0, 0);
      repeat (70) applyStimulus(1'b0, 1'b0, 0);
      repeat (100) applyStimulus(1'b0, 1'b0, 50);
      repeat (6) applyStimulus(1'b0, 1'b0, 0);

      @(posedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
